// File: rtl/mips_register_writer_if.sv
// Bus bundle for the MIPS register writer: two write-back request ports,
// the register file write port, the bypass lookup ports and the occupancy count.
interface mips_register_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 3
);
  logic              aValid;
  logic              aReady;
  logic [ADDR_W-1:0] aAddr;
  logic [DATA_W-1:0] aData;
  logic              bValid;
  logic              bReady;
  logic [ADDR_W-1:0] bAddr;
  logic [DATA_W-1:0] bData;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              wrEnable;
  logic              wrReady;
  logic [ADDR_W-1:0] rd1Addr;
  logic [ADDR_W-1:0] rd2Addr;
  logic              rd1Hit;
  logic              rd2Hit;
  logic [DATA_W-1:0] rd1Data;
  logic [DATA_W-1:0] rd2Data;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  aValid, aAddr, aData, bValid, bAddr, bData, wrReady, rd1Addr, rd2Addr,
    output aReady, bReady, wrAddr, wrData, wrEnable, rd1Hit, rd2Hit, rd1Data, rd2Data, count
  );

  modport master (
    output aValid, aAddr, aData, bValid, bAddr, bData, wrReady, rd1Addr, rd2Addr,
    input  aReady, bReady, wrAddr, wrData, wrEnable, rd1Hit, rd2Hit, rd1Data, rd2Data, count
  );
endinterface

// File: rtl/mips_register_writer.sv
// In-order write-back queue in front of the register file write port,
// with fixed-priority intake from two producers and a youngest-wins bypass lookup.
module mips_register_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_L = 32,
  parameter int ADDR_W = $clog2(ADDR_L),
  parameter int DEPTH  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mips_register_writer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic              full;
  logic              not_empty;
  logic              pop;
  logic              a_ready;
  logic              a_fire;
  logic              b_fire;
  logic              push;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  // Scan from head to tail so the last match seen is the youngest entry.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0]  result;
    logic [PTR_W-1:0] idx;
    result = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr != '0) && (addr_mem_q[idx] == addr)) begin
        result = {1'b1, data_mem_q[idx]};
      end
    end
    return result;
  endfunction

  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    not_empty = (count_q != '0);
    pop       = not_empty && bus.wrReady;
    a_ready   = !full || pop;
    a_fire    = bus.aValid && a_ready;
    b_fire    = bus.bValid && a_ready && !bus.aValid;
    push_addr = a_fire ? bus.aAddr : bus.bAddr;
    push_data = a_fire ? bus.aData : bus.bData;
    // Register 0 writes are acknowledged but never stored.
    push      = (a_fire || b_fire) && (push_addr != '0);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= push_addr;
      data_mem_q[wr_ptr_q] <= push_data;
    end
  end

  logic [DATA_W:0] rd1_result;
  logic [DATA_W:0] rd2_result;

  always_comb begin
    rd1_result   = lookup(bus.rd1Addr);
    rd2_result   = lookup(bus.rd2Addr);
    bus.aReady   = a_ready;
    bus.bReady   = a_ready && !bus.aValid;
    bus.wrEnable = not_empty;
    bus.wrAddr   = not_empty ? addr_mem_q[rd_ptr_q] : '0;
    bus.wrData   = not_empty ? data_mem_q[rd_ptr_q] : '0;
    bus.rd1Hit   = rd1_result[DATA_W];
    bus.rd1Data  = rd1_result[DATA_W-1:0];
    bus.rd2Hit   = rd2_result[DATA_W];
    bus.rd2Data  = rd2_result[DATA_W-1:0];
    bus.count    = count_q;
  end
endmodule

// File: tb/tb_mips_register_writer.sv
// Scoreboard bench for mips_register_writer: accepted requests are queued in a
// reference model and compared against the write port, readiness, count and bypass.
module tb_mips_register_writer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors_applied = 0;
  int   miscompares = 0;
  logic [36:0] sb [$];

  always #5 clk = ~clk;

  mips_register_writer_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(3)) bus ();

  mips_register_writer #(.DATA_W(32), .ADDR_L(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelLookup(input logic [4:0] addr, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    if (addr != 5'd0) begin
      foreach (sb[i]) begin
        if (sb[i][36:32] == addr) begin
          hit  = 1'b1;
          data = sb[i][31:0];
        end
      end
    end
  endtask

  // Drive one cycle just after a falling edge, check just before the rising edge.
  task automatic applyStimulus(input logic a_v, input logic [4:0] a_addr, input logic [31:0] a_data,
                               input logic b_v, input logic [4:0] b_addr, input logic [31:0] b_data,
                               input logic wr_rdy, input logic [4:0] rd1, input logic [4:0] rd2);
    logic        exp_en, exp_pop, exp_a_rdy, exp_b_rdy, hit;
    logic [31:0] data;
    bus.aValid  = a_v;  bus.aAddr = a_addr; bus.aData = a_data;
    bus.bValid  = b_v;  bus.bAddr = b_addr; bus.bData = b_data;
    bus.wrReady = wr_rdy;
    bus.rd1Addr = rd1;  bus.rd2Addr = rd2;
    #4;
    exp_en    = (sb.size() != 0);
    exp_pop   = exp_en && wr_rdy;
    exp_a_rdy = (sb.size() != DEPTH) || exp_pop;
    exp_b_rdy = exp_a_rdy && !a_v;
    checkOutput("count", 64'(bus.count), 64'(sb.size()));
    checkOutput("wrEnable", 64'(bus.wrEnable), 64'(exp_en));
    checkOutput("aReady", 64'(bus.aReady), 64'(exp_a_rdy));
    checkOutput("bReady", 64'(bus.bReady), 64'(exp_b_rdy));
    checkOutput("wrAddr", 64'(bus.wrAddr), exp_en ? 64'(sb[0][36:32]) : 64'd0);
    checkOutput("wrData", 64'(bus.wrData), exp_en ? 64'(sb[0][31:0]) : 64'd0);
    modelLookup(rd1, hit, data);
    checkOutput("rd1Hit", 64'(bus.rd1Hit), 64'(hit));
    checkOutput("rd1Data", 64'(bus.rd1Data), 64'(data));
    modelLookup(rd2, hit, data);
    checkOutput("rd2Hit", 64'(bus.rd2Hit), 64'(hit));
    checkOutput("rd2Data", 64'(bus.rd2Data), 64'(data));
    if (exp_pop) void'(sb.pop_front());
    if (a_v && exp_a_rdy) begin
      if (a_addr != 5'd0) sb.push_back({a_addr, a_data});
    end else if (b_v && exp_b_rdy && b_addr != 5'd0) begin
      sb.push_back({b_addr, b_data});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic wr_rdy, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(0, 0, 0, 0, 0, 0, wr_rdy, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.aValid = 0; bus.aAddr = 0; bus.aData = 0;
    bus.bValid = 0; bus.bAddr = 0; bus.bData = 0;
    bus.wrReady = 1; bus.rd1Addr = 0; bus.rd2Addr = 0;
    #1;
    checkOutput("rst_count", 64'(bus.count), 64'd0);
    checkOutput("rst_wrEnable", 64'(bus.wrEnable), 64'd0);
    checkOutput("rst_aReady", 64'(bus.aReady), 64'd1);
    checkOutput("rst_bReady", 64'(bus.bReady), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request reaches the write port on the next cycle.
    applyStimulus(1, 5, 32'h1234, 0, 0, 0, 1, 0, 0);
    checkOutput("t1_wrAddr", 64'(bus.wrAddr), 64'd5);
    checkOutput("t1_wrData", 64'(bus.wrData), 64'h1234);
    idle(1, 2);

    // Simultaneous requests: a wins, b retries the following cycle.
    applyStimulus(1, 3, 32'hA, 1, 4, 32'hB, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 4, 32'hB, 1, 0, 0);
    idle(1, 3);

    // Fill with the write port stalled, then push and pop together while full.
    for (int i = 0; i < 4; i++) applyStimulus(1, 5'(10 + i), 32'(100 + i), 0, 0, 0, 0, 0, 0);
    checkOutput("t3_full_count", 64'(bus.count), 64'd4);
    applyStimulus(1, 14, 32'd104, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 14, 32'd104, 0, 0, 0, 1, 12, 13);
    checkOutput("t3_pushpop_count", 64'(bus.count), 64'd4);
    idle(1, 6);

    // Writes to register 0 complete but never enter the queue.
    applyStimulus(1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 32'hFFFF, 1, 0, 0);
    idle(1, 1);

    // Bypass returns the youngest of two queued writes to one register.
    applyStimulus(1, 7, 32'd1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 7, 32'd2, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 0);
    checkOutput("t5_rd1Data", 64'(bus.rd1Data), 64'd2);
    checkOutput("t5_rd2Hit", 64'(bus.rd2Hit), 64'd0);
    idle(1, 3);

    // Reset mid-cycle with entries queued discards them immediately.
    for (int i = 1; i <= 3; i++) applyStimulus(1, 5'(i), 32'(i * 16), 0, 0, 0, 0, 0, 0);
    bus.aValid = 0; bus.rd1Addr = 5'd2;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_count", 64'(bus.count), 64'd0);
    checkOutput("t6_wrEnable", 64'(bus.wrEnable), 64'd0);
    checkOutput("t6_wrAddr", 64'(bus.wrAddr), 64'd0);
    checkOutput("t6_rd1Hit", 64'(bus.rd1Hit), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, 3);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(1, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule
